uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_counter.sv | 38 +++
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared types, default baud constants and parity helper for UART
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int unsigned UART_CLK_RATE      = 100_000_000;
    localparam int unsigned UART_BAUD_RATE     = 19_200;
    localparam int unsigned UART_BIT_CLKS      = UART_CLK_RATE / UART_BAUD_RATE;
    localparam int unsigned UART_HALF_BIT_CLKS = UART_BIT_CLKS / 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    // Parity bit value that makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// uart_baud_counter : bit-period counter, wraps at BIT_CLKS-1, ticks on target
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CLKS = UART_BIT_CLKS,
    parameter int unsigned CNT_W    = $clog2(BIT_CLKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] target,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count == CNT_W'(BIT_CLKS - 1)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == target);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8-O-1 serial receiver with parity/framing status strobe
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE  = UART_CLK_RATE,
    parameter int unsigned BAUD_RATE = UART_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_rx,
    output logic       data_strobe,
    output logic       parity_error,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int unsigned BIT_CLKS      = CLK_RATE / BAUD_RATE;
    localparam int unsigned HALF_BIT_CLKS = BIT_CLKS / 2;
    localparam int unsigned CNT_W         = $clog2(BIT_CLKS);

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        state;
    rx_state_t        state_next;
    logic             clear;
    logic             tick;
    logic [CNT_W-1:0] target;
    logic             busy_next;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_idx;
    logic             parity_bad;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_counter #(
        .BIT_CLKS (BIT_CLKS),
        .CNT_W    (CNT_W)
    ) u_baud_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .target (target),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        target     = CNT_W'(BIT_CLKS - 1);
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                target = CNT_W'(HALF_BIT_CLKS - 1);
                if (tick) begin
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && (bit_idx == 3'd7)) begin
                    state_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_next = rx_s ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // Every state entry restarts the bit timer; the idle states keep it parked.
        clear     = (state_next != state) || (state == ST_IDLE) || (state == ST_WAIT_IDLE);
        busy_next = state_next inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_rx       <= 8'h00;
            data_strobe   <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            rx_busy       <= 1'b0;
            shift_reg     <= 8'h00;
            bit_idx       <= 3'd0;
            parity_bad    <= 1'b0;
        end else begin
            data_strobe <= 1'b0;
            rx_busy     <= busy_next;
            if (tick) begin
                case (state)
                    ST_START: begin
                        bit_idx <= 3'd0;
                    end
                    ST_DATA: begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                    end
                    ST_PARITY: begin
                        parity_bad <= (rx_s != odd_parity(shift_reg));
                    end
                    ST_STOP: begin
                        data_rx       <= shift_reg;
                        data_strobe   <= 1'b1;
                        parity_error  <= parity_bad;
                        framing_error <= ~rx_s;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : scoreboard bench for uart_rx at a reduced bit period
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int BIT  = 20;
    localparam int HALF = 10;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_rx;
    logic       data_strobe;
    logic       parity_error;
    logic       framing_error;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    uart_rx #(
        .CLK_RATE  (100_000_000),
        .BAUD_RATE (5_000_000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .data_rx       (data_rx),
        .data_strobe   (data_strobe),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (data_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=strobe data_rx=%02h required=no strobe", data_rx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data_rx", {24'h0, data_rx}, {24'h0, e.data});
                check("parity_error", {31'h0, parity_error}, {31'h0, e.perr});
                check("framing_error", {31'h0, framing_error}, {31'h0, e.ferr});
                check("strobe_cycle", cyc, e.cyc);
                check("busy_at_strobe", {31'h0, rx_busy}, 32'h0);
            end
        end
    end

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int extra_low, input logic exp_pe, input logic exp_fe);
        exp_t e;
        e.data = d;
        e.perr = exp_pe;
        e.ferr = exp_fe;
        e.cyc  = cyc + 3 + HALF + 10 * BIT;
        sb.push_back(e);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        check("busy_in_frame", {31'h0, rx_busy}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = par;
        repeat (BIT) @(negedge clk);
        check("busy_late_frame", {31'h0, rx_busy}, 32'h1);
        rx = stop;
        repeat (BIT * (1 + extra_low)) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         ones;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_rx", {24'h0, data_rx}, 32'h0);
        check("reset_strobe", {31'h0, data_strobe}, 32'h0);
        check("reset_perr", {31'h0, parity_error}, 32'h0);
        check("reset_ferr", {31'h0, framing_error}, 32'h0);
        check("reset_busy", {31'h0, rx_busy}, 32'h0);
        rst = 1'b0;
        idle_bits(2);

        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle_bits(2);
        send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        idle_bits(1);
        send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        idle_bits(2);

        // Stop bit low and the line held low for three bit times in total.
        send_frame(8'h7E, 1'b1, 1'b0, 2, 1'b0, 1'b1);
        idle_bits(2);
        check("busy_after_break", {31'h0, rx_busy}, 32'h0);
        send_frame(8'h55, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle_bits(2);

        // Short glitch: busy rises then drops at the start sample, no strobe.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_high", {31'h0, rx_busy}, 32'h1);
        repeat (HALF - 1) @(negedge clk);
        check("glitch_busy_low", {31'h0, rx_busy}, 32'h0);
        idle_bits(2);
        check("glitch_data_held", {24'h0, data_rx}, 32'h55);
        check("glitch_perr_held", {31'h0, parity_error}, 32'h0);
        check("glitch_ferr_held", {31'h0, framing_error}, 32'h0);

        // 0xFF frame aborted by reset at the data-bit-4 sample point.
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (HALF + 2) @(negedge clk);
        check("pre_reset_busy", {31'h0, rx_busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("midreset_data_rx", {24'h0, data_rx}, 32'h0);
        check("midreset_strobe", {31'h0, data_strobe}, 32'h0);
        check("midreset_perr", {31'h0, parity_error}, 32'h0);
        check("midreset_ferr", {31'h0, framing_error}, 32'h0);
        check("midreset_busy", {31'h0, rx_busy}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        send_frame(8'h81, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle_bits(2);

        // Back-to-back frames from a transmitter model; parity bit set from a count of ones.
        for (int n = 0; n < 50; n++) begin
            b    = 8'($urandom_range(0, 255));
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(b[i]);
            send_frame(b, (ones % 2) == 0, 1'b1, 0, 1'b0, 1'b0);
        end
        idle_bits(3);
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
